// File: rtl/td4_execute_if.sv
// -----------------------------------------------------------------------------
// td4_execute_if
// Bundle between the TD4 decoder/fetch side and the execute/writeback stage.
//
// Signals (direction as seen from the execute stage, modport slave):
//   en          in   step enable, state advances only on enabled edges
//   sel         in   ALU source select (00=A, 10=B, 01=in_port, 11=zero)
//   load        in   active-low write enables {pc, out_port, reg_b, reg_a}
//   imm         in   instruction immediate
//   in_port     in   asynchronous external input switches
//   pc          out  program counter (instruction ROM address)
//   carry_flag  out  registered carry, fed back to the decoder for JNC
//   out_port    out  registered output port
//   reg_a       out  register A (observation)
//   reg_b       out  register B (observation)
// -----------------------------------------------------------------------------
interface td4_execute_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) ();

  logic              en;
  logic [1:0]        sel;
  logic [3:0]        load;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] in_port;
  logic [PC_W-1:0]   pc;
  logic              carry_flag;
  logic [DATA_W-1:0] out_port;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;

  // Decoder / stimulus side
  modport master (
    output en, sel, load, imm, in_port,
    input  pc, carry_flag, out_port, reg_a, reg_b
  );

  // Execute stage side
  modport slave (
    input  en, sel, load, imm, in_port,
    output pc, carry_flag, out_port, reg_a, reg_b
  );

endinterface

// File: rtl/td4_execute.sv
// -----------------------------------------------------------------------------
// td4_execute
// Execute/writeback stage of the TD4 4-bit CPU. Holds registers A and B, the
// output port latch, the program counter and the carry flag. Each enabled
// edge adds the selected source to the immediate and writes the sum to every
// destination whose active-low load bit is 0; the PC increments otherwise.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high; clears all state and the synchroniser
//   bus    td4_execute_if.slave (en, sel, load, imm, in_port in;
//          pc, carry_flag, out_port, reg_a, reg_b out, all registered)
// -----------------------------------------------------------------------------
module td4_execute #(
  parameter int DATA_W      = 4,
  parameter int PC_W        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  td4_execute_if.slave bus
);

  // Clamp so a misconfigured depth still yields a working synchroniser
  localparam int SYNC_N = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  logic [SYNC_N-1:0][DATA_W-1:0] sync_q, sync_d;
  logic [DATA_W-1:0]             reg_a_q, reg_a_d;
  logic [DATA_W-1:0]             reg_b_q, reg_b_d;
  logic [DATA_W-1:0]             out_port_q, out_port_d;
  logic [PC_W-1:0]               pc_q, pc_d;
  logic                          carry_q, carry_d;

  logic [DATA_W-1:0]             alu_src;
  logic [DATA_W:0]               alu_full;
  logic [DATA_W-1:0]             alu_sum;
  logic                          alu_c;

  // Input synchroniser shift: free-running, independent of en
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.in_port;
    for (int i = 1; i < SYNC_N; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // ALU source mux; any unknown/unused select reads as zero so a not-taken
  // JNC with a don't-care select cannot disturb architectural state
  always_comb begin
    alu_src = {DATA_W{1'b0}};
    case (bus.sel)
      2'b00:   alu_src = reg_a_q;
      2'b10:   alu_src = reg_b_q;
      2'b01:   alu_src = sync_q[SYNC_N-1];
      default: alu_src = {DATA_W{1'b0}};
    endcase
  end

  // ALU adder, one bit wider to capture carry-out
  always_comb begin
    alu_full = {1'b0, alu_src} + {1'b0, bus.imm};
    alu_sum  = alu_full[DATA_W-1:0];
    alu_c    = alu_full[DATA_W];
  end

  // Architectural next-state: writeback selected by active-low load bits
  always_comb begin
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    out_port_d = out_port_q;
    pc_d       = pc_q;
    carry_d    = carry_q;
    if (bus.en) begin
      carry_d = alu_c;
      if (!bus.load[0]) begin
        reg_a_d = alu_sum;
      end else begin
        reg_a_d = reg_a_q;
      end
      if (!bus.load[1]) begin
        reg_b_d = alu_sum;
      end else begin
        reg_b_d = reg_b_q;
      end
      if (!bus.load[2]) begin
        out_port_d = alu_sum;
      end else begin
        out_port_d = out_port_q;
      end
      if (!bus.load[3]) begin
        pc_d = PC_W'(alu_sum);
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end else begin
      carry_d = carry_q;
    end
  end

  // State registers with synchronous reset taking priority over en
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      reg_a_q    <= {DATA_W{1'b0}};
      reg_b_q    <= {DATA_W{1'b0}};
      out_port_q <= {DATA_W{1'b0}};
      pc_q       <= {PC_W{1'b0}};
      carry_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      out_port_q <= out_port_d;
      pc_q       <= pc_d;
      carry_q    <= carry_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.carry_flag = carry_q;
  assign bus.out_port   = out_port_q;
  assign bus.reg_a      = reg_a_q;
  assign bus.reg_b      = reg_b_q;

endmodule
